// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file.
//   RF_DW / RF_AW : default data and address widths
//   rf_state_e    : array state (CLEAR while zeroing, IDLE when usable)
//   clear_base()  : first register index touched by a clear sequence
package regfile_mp_pkg;

  localparam int RF_DW = 32;
  localparam int RF_AW = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } rf_state_e;

  // Register 0 needs no zeroing when it is hardwired, so the sweep starts at 1.
  function automatic int clear_base(input int zero_reg);
    return (zero_reg != 0) ? 1 : 0;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle of the multi-port register file.
//   clr_req / rdy             : clear request, array-usable flag
//   radd / rdat / rbusy       : NR read ports (address, data, pending flag)
//   wen / wadd / wdat         : NW write ports
//   iss_en / iss_add          : mark a register as awaiting a future write
// master = client side, slave = register file side.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW,
  parameter int NR = 2,
  parameter int NW = 2
);

  logic             clr_req;
  logic             rdy;
  logic [NR*AW-1:0] radd;
  logic [NR*DW-1:0] rdat;
  logic [NR-1:0]    rbusy;
  logic [NW-1:0]    wen;
  logic [NW*AW-1:0] wadd;
  logic [NW*DW-1:0] wdat;
  logic             iss_en;
  logic [AW-1:0]    iss_add;

  modport master (
    output clr_req, radd, wen, wadd, wdat, iss_en, iss_add,
    input  rdy, rdat, rbusy
  );

  modport slave (
    input  clr_req, radd, wen, wadd, wdat, iss_en, iss_add,
    output rdy, rdat, rbusy
  );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
//   clk, rst : clock, synchronous active-high reset (clears every bit)
//   set_en   : mark set_add busy (a producer has been issued)
//   set_add  : register being marked
//   clr_en   : per write port, the write commits this cycle
//   clr_add  : per write port address (port k in slice k)
//   busy     : current busy vector
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int AW       = RF_AW,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [AW-1:0]       set_add,
  input  logic [NW-1:0]       clr_en,
  input  logic [NW*AW-1:0]    clr_add,
  output logic [(2**AW)-1:0]  busy
);

  localparam int DEPTH = 2**AW;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NW; k++) begin
      if (clr_en[k]) busy_d[clr_add[k*AW +: AW]] = 1'b0;
    end
    // Applied after the clears: a newly issued producer supersedes the one
    // whose result is landing this cycle.
    if (set_en) busy_d[set_add] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with bypassed reads, a pending-write scoreboard
// and a sequential clear engine.
//   clk, rst : clock, synchronous active-high reset (starts a full clear)
//   bus      : regfile_mp_if slave port (clear request/rdy, NR read ports,
//              NW write ports, issue port)
// Reads are combinational and see same-cycle writes; the highest-indexed
// write port wins on address collisions, both in the array and the bypass.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int AW       = RF_AW,
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int            DEPTH     = 2**AW;
  localparam logic [AW-1:0] CNT_START = AW'(clear_base(ZERO_REG));
  localparam logic [AW-1:0] CNT_LAST  = AW'(DEPTH - 1);

  rf_state_e     state_q;
  logic [AW-1:0] cnt_q;
  logic          rdy_q;

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] radd_a [NR];
  logic [DW-1:0] rdat_a [NR];
  logic [NR-1:0] rbusy_v;
  logic [AW-1:0] wadd_a [NW];
  logic [DW-1:0] wdat_a [NW];

  logic             wr_ok;
  logic [NW-1:0]    wr_commit;
  logic [DEPTH-1:0] busy;

  for (genvar i = 0; i < NR; i++) begin : g_rd
    assign radd_a[i]              = bus.radd[i*AW +: AW];
    assign bus.rdat[i*DW +: DW]   = rdat_a[i];
  end

  for (genvar k = 0; k < NW; k++) begin : g_wr
    assign wadd_a[k] = bus.wadd[k*AW +: AW];
    assign wdat_a[k] = bus.wdat[k*DW +: DW];
  end

  // Writes and issues only take effect in IDLE and never on a reset edge.
  assign wr_ok     = rdy_q & ~rst;
  assign wr_commit = bus.wen & {NW{wr_ok}};

  // Clear FSM: rdy is registered alongside the state so it is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= CNT_START;
      rdy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.clr_req) begin
            state_q <= ST_CLEAR;
            cnt_q   <= CNT_START;
            rdy_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          cnt_q   <= CNT_START;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  // Array: one register zeroed per cycle while clearing, otherwise the write
  // ports. Later loop iterations override earlier ones, so the highest port
  // wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < NW; k++) begin
        if (bus.wen[k] && !(ZERO_REG != 0 && wadd_a[k] == '0)) begin
          mem_q[wadd_a[k]] <= wdat_a[k];
        end
      end
    end
  end

  regfile_scoreboard #(
    .AW       (AW),
    .NW       (NW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (bus.iss_en & wr_ok),
    .set_add (bus.iss_add),
    .clr_en  (wr_commit),
    .clr_add (bus.wadd),
    .busy    (busy)
  );

  // Read ports: array value, overridden by the highest matching write port.
  // A bypassed read reports not-busy because its producer is landing now.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      rdat_a[i]  = '0;
      rbusy_v[i] = 1'b0;
      if (rdy_q && !(ZERO_REG != 0 && radd_a[i] == '0)) begin
        rdat_a[i]  = mem_q[radd_a[i]];
        rbusy_v[i] = busy[radd_a[i]];
        for (int k = 0; k < NW; k++) begin
          if (wr_commit[k] && wadd_a[k] == radd_a[i]) begin
            rdat_a[i]  = wdat_a[k];
            rbusy_v[i] = 1'b0;
          end
        end
      end
    end
  end

  assign bus.rbusy = rbusy_v;
  assign bus.rdy   = rdy_q;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int NREG = 32;
  localparam int CLEAR_CYCLES = 31;

  logic clk = 1'b0;
  logic rst = 1'b0;

  regfile_mp_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) bus ();

  regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // Behavioural model: register contents, pending set, and how many clear
  // cycles remain before the array becomes usable again.
  logic [DW-1:0] m_mem  [NREG];
  bit            m_busy [NREG];
  bit            m_rdy = 1'b0;
  int            m_left = 0;

  initial for (int a = 0; a < NREG; a++) begin m_mem[a] = '0; m_busy[a] = 1'b0; end

  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < NREG; a++) m_busy[a] = 1'b0;
      m_rdy  = 1'b0;
      m_left = CLEAR_CYCLES;
    end else if (!m_rdy) begin
      m_left--;
      if (m_left == 0) begin
        m_rdy = 1'b1;
        for (int a = 0; a < NREG; a++) m_mem[a] = '0;
      end
    end else begin
      for (int k = 0; k < NW; k++) begin
        int wa;
        wa = int'(bus.wadd[k*AW +: AW]);
        if (bus.wen[k]) begin
          if (wa != 0) m_mem[wa] = bus.wdat[k*DW +: DW];
          m_busy[wa] = 1'b0;
        end
      end
      if (bus.iss_en && bus.iss_add != '0) m_busy[int'(bus.iss_add)] = 1'b1;
      if (bus.clr_req) begin
        m_rdy  = 1'b0;
        m_left = CLEAR_CYCLES;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("rdy", 64'(bus.rdy), 64'(m_rdy));
      for (int i = 0; i < NR; i++) begin
        int            ra;
        logic [DW-1:0] ed;
        bit            eb;
        ra = int'(bus.radd[i*AW +: AW]);
        ed = '0;
        eb = 1'b0;
        if (m_rdy && ra != 0) begin
          ed = m_mem[ra];
          eb = m_busy[ra];
          if (!rst) begin
            for (int k = 0; k < NW; k++) begin
              if (bus.wen[k] && int'(bus.wadd[k*AW +: AW]) == ra) begin
                ed = bus.wdat[k*DW +: DW];
                eb = 1'b0;
              end
            end
          end
        end
        check($sformatf("model_rdat%0d@%0d", i, ra), 64'(bus.rdat[i*DW +: DW]), 64'(ed));
        check($sformatf("model_rbusy%0d@%0d", i, ra), 64'(bus.rbusy[i]), 64'(eb));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clr_req = 1'b0;
    bus.wen     = '0;
    bus.wadd    = '0;
    bus.wdat    = '0;
    bus.iss_en  = 1'b0;
    bus.iss_add = '0;
  endtask

  task automatic set_radd(input int p, input int a);
    bus.radd[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
    bus.wen[p]           = 1'b1;
    bus.wadd[p*AW +: AW] = AW'(a);
    bus.wdat[p*DW +: DW] = d;
  endtask

  // Counts remaining negedges with rdy low, bounded so the run always ends.
  task automatic count_low(inout int n);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.rdy) return;
      n++;
    end
  endtask

  // Reads every register through both ports and expects zero, not busy.
  task automatic scan_zero(input string tag);
    for (int a = 0; a < NREG; a++) begin
      set_radd(0, a);
      set_radd(1, NREG - 1 - a);
      @(negedge clk);
      check($sformatf("%s_rdat@%0d", tag, a), 64'(bus.rdat[DW-1:0]), 64'h0);
      check($sformatf("%s_rbusy@%0d", tag, a), 64'(bus.rbusy[0]), 64'h0);
      tick();
    end
  endtask

  initial begin
    int n;
    idle_inputs();
    bus.radd = '0;

    // Reset and initial clear
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    n = 0;
    count_low(n);
    check("reset_clear_cycles", 64'(n), 64'd31);
    check("reset_rdy_up", 64'(bus.rdy), 64'h1);
    tick();
    scan_zero("after_reset");

    // Two ports write reg 5 in one cycle: port 1 wins, bypass and array agree
    set_wr(0, 5, 32'h55550000);
    set_wr(1, 5, 32'hAAAA0001);
    set_radd(0, 5);
    @(negedge clk);
    check("collide_bypass", 64'(bus.rdat[DW-1:0]), 64'hAAAA0001);
    tick();
    idle_inputs();
    @(negedge clk);
    check("collide_stored", 64'(bus.rdat[DW-1:0]), 64'hAAAA0001);
    tick();

    // Register 0 is hardwired
    set_wr(0, 0, 32'hDEADBEEF);
    set_radd(0, 0);
    bus.iss_en  = 1'b1;
    bus.iss_add = '0;
    @(negedge clk);
    check("zero_bypass", 64'(bus.rdat[DW-1:0]), 64'h0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("zero_stored", 64'(bus.rdat[DW-1:0]), 64'h0);
    check("zero_busy", 64'(bus.rbusy[0]), 64'h0);
    tick();

    // Scoreboard on reg 7
    bus.iss_en  = 1'b1;
    bus.iss_add = 5'd7;
    set_radd(0, 7);
    tick();
    idle_inputs();
    @(negedge clk);
    check("iss_busy", 64'(bus.rbusy[0]), 64'h1);
    tick();
    set_wr(1, 7, 32'h12345678);
    @(negedge clk);
    check("wr_bypass_busy", 64'(bus.rbusy[0]), 64'h0);
    check("wr_bypass_data", 64'(bus.rdat[DW-1:0]), 64'h12345678);
    tick();
    idle_inputs();
    @(negedge clk);
    check("wr_cleared_busy", 64'(bus.rbusy[0]), 64'h0);
    tick();
    set_wr(0, 7, 32'h0BADF00D);
    bus.iss_en  = 1'b1;
    bus.iss_add = 5'd7;
    tick();
    idle_inputs();
    @(negedge clk);
    check("set_wins_busy", 64'(bus.rbusy[0]), 64'h1);
    check("set_wins_data", 64'(bus.rdat[DW-1:0]), 64'h0BADF00D);
    tick();

    // Fill 1..31, then clear with junk traffic during the sweep
    for (int a = 1; a < NREG; a++) begin
      set_wr(0, a, 32'(a) * 32'h01010101);
      tick();
    end
    idle_inputs();
    set_radd(0, 9);
    set_radd(1, 31);
    @(negedge clk);
    check("fill_r9", 64'(bus.rdat[DW-1:0]), 64'h09090909);
    check("fill_r31", 64'(bus.rdat[2*DW-1:DW]), 64'h1F1F1F1F);
    tick();
    bus.clr_req = 1'b1;
    tick();
    n = 0;
    for (int c = 0; c < 5; c++) begin
      set_wr(0, 3 + c, 32'hCAFE0000 + 32'(c));
      set_wr(1, 20 + c, 32'hBEEF0000 + 32'(c));
      bus.iss_en  = 1'b1;
      bus.iss_add = AW'(10 + c);
      bus.clr_req = 1'b1;
      @(negedge clk);
      if (!bus.rdy) n++;
      tick();
    end
    idle_inputs();
    count_low(n);
    check("clr_cycles", 64'(n), 64'd31);
    tick();
    scan_zero("after_clr");

    // Reset 10 cycles into a clear restarts the whole sweep
    bus.iss_en  = 1'b1;
    bus.iss_add = 5'd3;
    tick();
    bus.iss_add = 5'd12;
    set_radd(0, 3);
    tick();
    idle_inputs();
    @(negedge clk);
    check("pre_rst_busy3", 64'(bus.rbusy[0]), 64'h1);
    tick();
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    count_low(n);
    check("rst_mid_clear_cycles", 64'(n), 64'd31);
    tick();
    scan_zero("after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
